// File: rtl/snake_pkg.sv
// Shared types for the snake game output-side blocks.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOOD = 2'd1,
        BAD  = 2'd2
    } fb_state_t;

endpackage

// File: rtl/collision_feedback_if.sv
// Collision event inputs and buzzer/LED outputs of the feedback driver.
interface collision_feedback_if;

    logic goodColl_i;
    logic badColl_i;
    logic mute_i;
    logic tone_o;
    logic goodLed_o;
    logic badLed_o;
    logic busy_o;

    modport master (
        output goodColl_i, badColl_i, mute_i,
        input  tone_o, goodLed_o, badLed_o, busy_o
    );

    modport slave (
        input  goodColl_i, badColl_i, mute_i,
        output tone_o, goodLed_o, badLed_o, busy_o
    );

endinterface

// File: rtl/collision_feedback_tone_gen.sv
// Square-wave generator: starts high on load, toggles every half_load+1 cycles while run.
module tone_gen #(
    parameter int unsigned HALF_W = 1
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              load,
    input  logic [HALF_W-1:0] half_load,
    input  logic              run,
    output logic              tone_q
);

    logic [HALF_W-1:0] half_q;
    logic [HALF_W-1:0] half_d;
    logic              tone_d;

    // Next half-period count and tone level; dropping both load and run silences the tone.
    always_comb begin
        half_d = half_q;
        tone_d = tone_q;
        if (load) begin
            half_d = half_load;
            tone_d = 1'b1;
        end else if (run) begin
            if (half_q == '0) begin
                tone_d = ~tone_q;
                half_d = half_load;
            end else begin
                half_d = half_q - HALF_W'(1);
            end
        end else begin
            tone_d = 1'b0;
        end
    end

    // Counter and tone registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            half_q <= '0;
            tone_q <= 1'b0;
        end else begin
            half_q <= half_d;
            tone_q <= tone_d;
        end
    end

endmodule

// File: rtl/collision_feedback.sv
// Turns single-cycle collision pulses into timed buzzer tone and LED indications.
module collision_feedback
    import snake_pkg::*;
#(
    parameter int unsigned GOOD_CYCLES = 3_000_000,
    parameter int unsigned GOOD_HALF   = 6_000,
    parameter int unsigned BAD_CYCLES  = 6_000_000,
    parameter int unsigned BAD_HALF    = 15_000
) (
    input  logic                 clk,
    input  logic                 nRst,
    collision_feedback_if.slave  fb
);

    localparam int unsigned MAX_CYC = (GOOD_CYCLES > BAD_CYCLES) ? GOOD_CYCLES : BAD_CYCLES;
    localparam int unsigned MAX_HLF = (GOOD_HALF > BAD_HALF) ? GOOD_HALF : BAD_HALF;
    localparam int unsigned DUR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned HALF_W  = (MAX_HLF > 1) ? $clog2(MAX_HLF) : 1;

    localparam logic [DUR_W-1:0]  GOOD_DUR_LD  = DUR_W'(GOOD_CYCLES - 1);
    localparam logic [DUR_W-1:0]  BAD_DUR_LD   = DUR_W'(BAD_CYCLES - 1);
    localparam logic [HALF_W-1:0] GOOD_HALF_LD = HALF_W'(GOOD_HALF - 1);
    localparam logic [HALF_W-1:0] BAD_HALF_LD  = HALF_W'(BAD_HALF - 1);

    fb_state_t         state_q, state_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              good_led_q, bad_led_q, busy_q;
    logic              start_bad, start_good;
    logic              tone_load, tone_run;
    logic [HALF_W-1:0] half_load;
    logic              tone_q;

    // Event arbitration: bad restarts from anywhere, good only outside BAD, bad wins ties.
    always_comb begin
        start_bad  = fb.badColl_i;
        start_good = fb.goodColl_i && !fb.badColl_i && (state_q != BAD);
        state_d    = state_q;
        dur_d      = dur_q;
        tone_load  = 1'b0;
        tone_run   = 1'b0;
        half_load  = (state_q == BAD) ? BAD_HALF_LD : GOOD_HALF_LD;
        if (start_bad) begin
            state_d   = BAD;
            dur_d     = BAD_DUR_LD;
            tone_load = 1'b1;
            half_load = BAD_HALF_LD;
        end else if (start_good) begin
            state_d   = GOOD;
            dur_d     = GOOD_DUR_LD;
            tone_load = 1'b1;
            half_load = GOOD_HALF_LD;
        end else if (state_q != IDLE) begin
            if (dur_q == '0) begin
                state_d = IDLE;
            end else begin
                dur_d    = dur_q - DUR_W'(1);
                tone_run = 1'b1;
            end
        end
    end

    // State, duration counter and LED/busy registers (LEDs track the next state).
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            dur_q      <= '0;
            good_led_q <= 1'b0;
            bad_led_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dur_q      <= dur_d;
            good_led_q <= (state_d == GOOD);
            bad_led_q  <= (state_d == BAD);
            busy_q     <= (state_d != IDLE);
        end
    end

    tone_gen #(
        .HALF_W (HALF_W)
    ) u_tone_gen (
        .clk       (clk),
        .nRst      (nRst),
        .load      (tone_load),
        .half_load (half_load),
        .run       (tone_run),
        .tone_q    (tone_q)
    );

    assign fb.tone_o    = tone_q & ~fb.mute_i;
    assign fb.goodLed_o = good_led_q;
    assign fb.badLed_o  = bad_led_q;
    assign fb.busy_o    = busy_q;

endmodule

// File: tb/tb_collision_feedback.sv
// Bench for collision_feedback: directed vector table, reset cases, randomized run vs. model.
module tb_collision_feedback;

    localparam int unsigned GC = 6;
    localparam int unsigned GH = 2;
    localparam int unsigned BC = 8;
    localparam int unsigned BH = 1;

    logic clk;
    logic nRst;

    collision_feedback_if fb_if ();

    collision_feedback #(
        .GOOD_CYCLES (GC),
        .GOOD_HALF   (GH),
        .BAD_CYCLES  (BC),
        .BAD_HALF    (BH)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .fb   (fb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: active event kind and its age in cycles since the trigger.
    int m_kind = 0; // 0 idle, 1 good, 2 bad
    int m_age  = 0;

    function automatic int cyc_of(input int k);
        return (k == 2) ? int'(BC) : int'(GC);
    endfunction

    function automatic int half_of(input int k);
        return (k == 2) ? int'(BH) : int'(GH);
    endfunction

    task automatic model_step(input logic g, input logic b);
        if (b) begin
            m_kind = 2;
            m_age  = 0;
        end else if (g && m_kind != 2) begin
            m_kind = 1;
            m_age  = 0;
        end else if (m_kind != 0) begin
            m_age++;
            if (m_age >= cyc_of(m_kind)) m_kind = 0;
        end
    endtask

    function automatic logic model_tone(input logic m);
        if (m_kind == 0 || m) return 1'b0;
        return ((m_age / half_of(m_kind)) % 2) == 0;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".tone"}, fb_if.tone_o,    1'b0);
        chk({nm, ".good"}, fb_if.goodLed_o, 1'b0);
        chk({nm, ".bad"},  fb_if.badLed_o,  1'b0);
        chk({nm, ".busy"}, fb_if.busy_o,    1'b0);
    endtask

    // Drive inputs (called at negedge), clock once, sample at the next negedge.
    task automatic cycle(input logic g, input logic b, input logic m);
        fb_if.goodColl_i = g;
        fb_if.badColl_i  = b;
        fb_if.mute_i     = m;
        @(posedge clk);
        model_step(g, b);
        @(negedge clk);
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".tone"}, fb_if.tone_o,    model_tone(fb_if.mute_i));
        chk({nm, ".good"}, fb_if.goodLed_o, m_kind == 1);
        chk({nm, ".bad"},  fb_if.badLed_o,  m_kind == 2);
        chk({nm, ".busy"}, fb_if.busy_o,    m_kind != 0);
    endtask

    typedef struct {
        logic g, b, m;
        logic eg, eb, et;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic g, b, m, eg, eb, et);
        vec_t v;
        v.g = g; v.b = b; v.m = m; v.eg = eg; v.eb = eb; v.et = et;
        vecs.push_back(v);
    endtask

    initial begin
        // Single good pulse: tone 1,1,0,0,1,1 then idle
        add(1,0,0, 1,0,1); add(0,0,0, 1,0,1); add(0,0,0, 1,0,0);
        add(0,0,0, 1,0,0); add(0,0,0, 1,0,1); add(0,0,0, 1,0,1);
        add(0,0,0, 0,0,0); add(0,0,0, 0,0,0);
        // Single bad pulse: tone alternates every cycle for 8 cycles
        add(0,1,0, 0,1,1); add(0,0,0, 0,1,0); add(0,0,0, 0,1,1); add(0,0,0, 0,1,0);
        add(0,0,0, 0,1,1); add(0,0,0, 0,1,0); add(0,0,0, 0,1,1); add(0,0,0, 0,1,0);
        add(0,0,0, 0,0,0); add(0,0,0, 0,0,0);
        // Simultaneous pulses -> BAD; good at cycle 3 ignored; idle at cycle 9
        add(1,1,0, 0,1,1); add(0,0,0, 0,1,0); add(1,0,0, 0,1,1); add(0,0,0, 0,1,0);
        add(0,0,0, 0,1,1); add(0,0,0, 0,1,0); add(0,0,0, 0,1,1); add(0,0,0, 0,1,0);
        add(0,0,0, 0,0,0); add(0,0,0, 0,0,0);
        // Retrigger good at edge 4: LED through cycle 10, phase restarts at cycle 5
        add(1,0,0, 1,0,1); add(0,0,0, 1,0,1); add(0,0,0, 1,0,0); add(0,0,0, 1,0,0);
        add(1,0,0, 1,0,1); add(0,0,0, 1,0,1); add(0,0,0, 1,0,0); add(0,0,0, 1,0,0);
        add(0,0,0, 1,0,1); add(0,0,0, 1,0,1); add(0,0,0, 0,0,0); add(0,0,0, 0,0,0);
        // Pulse on the terminal cycle restarts without an idle gap
        add(1,0,0, 1,0,1); add(0,0,0, 1,0,1); add(0,0,0, 1,0,0); add(0,0,0, 1,0,0);
        add(0,0,0, 1,0,1); add(0,0,0, 1,0,1); add(1,0,0, 1,0,1); add(0,0,0, 1,0,1);
        add(0,0,0, 1,0,0); add(0,0,0, 1,0,0); add(0,0,0, 1,0,1); add(0,0,0, 1,0,1);
        add(0,0,0, 0,0,0);
        // Muted bad event: LED full 8 cycles, no tone
        add(0,1,1, 0,1,0);
        for (int i = 0; i < 7; i++) add(0,0,1, 0,1,0);
        add(0,0,1, 0,0,0); add(0,0,0, 0,0,0);

        // Reset held low with random inputs, checked mid-cycle and at negedge
        nRst = 1'b0;
        fb_if.goodColl_i = 1'b0;
        fb_if.badColl_i  = 1'b0;
        fb_if.mute_i     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fb_if.goodColl_i = 1'($urandom_range(0, 1));
            fb_if.badColl_i  = 1'($urandom_range(0, 1));
            fb_if.mute_i     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
            chk_zero($sformatf("rst_hold%0d", i));
            @(negedge clk);
        end
        fb_if.goodColl_i = 1'b0;
        fb_if.badColl_i  = 1'b0;
        fb_if.mute_i     = 1'b0;
        nRst   = 1'b1;
        m_kind = 0;
        m_age  = 0;
        cycle(1'b0, 1'b0, 1'b0);
        chk_zero("post_rst");

        // Directed vector table
        foreach (vecs[i]) begin
            cycle(vecs[i].g, vecs[i].b, vecs[i].m);
            chk($sformatf("vec%0d.tone", i), fb_if.tone_o,    vecs[i].et);
            chk($sformatf("vec%0d.good", i), fb_if.goodLed_o, vecs[i].eg);
            chk($sformatf("vec%0d.bad",  i), fb_if.badLed_o,  vecs[i].eb);
            chk($sformatf("vec%0d.busy", i), fb_if.busy_o,    vecs[i].eg | vecs[i].eb);
        end

        // Reset asserted mid-event at cycle 3 of a bad event
        cycle(1'b0, 1'b1, 1'b0);
        chk_model("midrst_c1");
        cycle(1'b0, 1'b0, 1'b0);
        chk_model("midrst_c2");
        @(posedge clk);
        model_step(1'b0, 1'b0);
        #2;
        chk_model("midrst_c3");
        nRst = 1'b0;
        #1;
        chk_zero("midrst_async");
        m_kind = 0;
        m_age  = 0;
        @(negedge clk);
        cycle(1'b1, 1'b1, 1'b0);
        m_kind = 0;
        m_age  = 0;
        chk_zero("midrst_held");
        fb_if.goodColl_i = 1'b0;
        fb_if.badColl_i  = 1'b0;
        nRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            chk_zero($sformatf("midrst_idle%0d", i));
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 17) == 0),
                  1'($urandom_range(0, 7) == 0));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
